// File: rtl/link_pkg.sv
// Shared definitions for the link-port serial transceiver: FSM states and
// default timing parameters.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    M_LOW  = 2'd1,
    M_HIGH = 2'd2,
    S_XFER = 2'd3
  } state_e;

  localparam int CLK_HALF_DEF = 488;
  localparam int TIMEOUT_DEF  = 65535;

endpackage

// File: rtl/lp_sync.sv
// Two-flop synchronizer for asynchronous link-port pins; idles high so a
// reset looks like an undriven, pulled-up line.
module lp_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/link_port_xcvr.sv
// Link-port byte transceiver: MSB-first shift on a self-generated (master)
// or peer-supplied (slave) serial clock, with slave inactivity timeout.
module link_port_xcvr
  import link_pkg::*;
#(
  parameter int CLK_HALF = CLK_HALF_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic       clk_8m,
  input  logic       rst_n,
  input  logic       lp_clk_in,
  output logic       lp_clk_out,
  output logic       lp_clk_oe,
  input  logic       lp_din,
  output logic       lp_dout,
  input  logic [7:0] tx_data,
  input  logic       start,
  input  logic       int_clk,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int HW = $clog2(CLK_HALF + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HALF_END = HW'(CLK_HALF - 1);
  localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT - 1);

  logic          clk_s;
  logic          din_s;
  logic          clk_prev_q;
  logic          clk_rise;
  logic          clk_fall;
  logic [7:0]    shifted;

  state_e        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    rx_q, rx_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [HW-1:0] half_q, half_d;
  logic [TW-1:0] to_q, to_d;
  logic          dout_q, dout_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  lp_sync #(.WIDTH(1)) u_sync_clk (
    .clk_i  (clk_8m),
    .rst_ni (rst_n),
    .d_i    (lp_clk_in),
    .q_o    (clk_s)
  );

  lp_sync #(.WIDTH(1)) u_sync_din (
    .clk_i  (clk_8m),
    .rst_ni (rst_n),
    .d_i    (lp_din),
    .q_o    (din_s)
  );

  assign clk_rise = clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s & clk_prev_q;
  assign shifted  = {sr_q[6:0], din_s};

  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= 8'hFF;
      rx_q       <= 8'h00;
      cnt_q      <= 3'd0;
      last_q     <= 1'b0;
      half_q     <= '0;
      to_q       <= '0;
      dout_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      half_q     <= half_d;
      to_q       <= to_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clk_prev_q <= clk_s;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    half_d  = half_q;
    to_d    = to_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d   = tx_data;
          cnt_d  = 3'd0;
          last_d = 1'b0;
          half_d = '0;
          to_d   = '0;
          // Master: this acceptance edge is also the first serial falling edge.
          if (int_clk) begin
            state_d = M_LOW;
            dout_d  = tx_data[7];
          end else begin
            state_d = S_XFER;
          end
        end
      end

      M_LOW: begin
        if (half_q == HALF_END) begin
          half_d  = '0;
          state_d = M_HIGH;
          sr_d    = shifted;
          if (cnt_q == 3'd7) last_d = 1'b1;
          else               cnt_d  = cnt_q + 3'd1;
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      M_HIGH: begin
        if (half_q == HALF_END) begin
          half_d = '0;
          dout_d = sr_q[7];
          if (last_q) begin
            state_d = IDLE;
            rx_d    = sr_q;
            done_d  = 1'b1;
          end else begin
            state_d = M_LOW;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      S_XFER: begin
        // A clock edge takes priority over a coincident timeout expiry.
        if (clk_fall) begin
          to_d   = '0;
          dout_d = sr_q[7];
        end else if (clk_rise) begin
          to_d = '0;
          sr_d = shifted;
          if (cnt_q == 3'd7) begin
            last_d  = 1'b1;
            state_d = IDLE;
            rx_d    = shifted;
            done_d  = 1'b1;
            dout_d  = sr_q[6];
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (to_q == TO_END) begin
          state_d = IDLE;
          err_d   = 1'b1;
          dout_d  = sr_q[7];
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign lp_dout    = dout_q;
  assign lp_clk_out = (state_q != M_LOW);
  assign lp_clk_oe  = (state_q == M_LOW) || (state_q == M_HIGH);
  assign busy       = (state_q != IDLE);
  assign rx_data    = rx_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_link_port_xcvr.sv
// Directed bench for link_port_xcvr: table of byte transfers plus hand
// sequences for repeated start and mid-transfer reset.
module tb_link_port_xcvr;

  localparam int CLK_HALF = 488;
  localparam int TIMEOUT  = 2000;
  localparam int PERIOD   = 2 * CLK_HALF;

  logic       clk_8m;
  logic       rst_n;
  logic       lp_clk_in;
  logic       lp_clk_out;
  logic       lp_clk_oe;
  logic       lp_din;
  logic       lp_dout;
  logic [7:0] tx_data;
  logic       start;
  logic       int_clk;
  logic [7:0] rx_data;
  logic       done;
  logic       err;
  logic       busy;

  logic       loop_en;
  logic       din_drv;

  int n_total;
  int n_pass;

  assign lp_din = loop_en ? lp_dout : din_drv;

  link_port_xcvr #(.CLK_HALF(CLK_HALF), .TIMEOUT(TIMEOUT)) dut (
    .clk_8m     (clk_8m),
    .rst_n      (rst_n),
    .lp_clk_in  (lp_clk_in),
    .lp_clk_out (lp_clk_out),
    .lp_clk_oe  (lp_clk_oe),
    .lp_din     (lp_din),
    .lp_dout    (lp_dout),
    .tx_data    (tx_data),
    .start      (start),
    .int_clk    (int_clk),
    .rx_data    (rx_data),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  initial clk_8m = 1'b0;
  always #5 clk_8m = ~clk_8m;

  typedef struct {
    logic       master;
    logic       loop;
    logic [7:0] tx;
    logic [7:0] din;
    int         nclk;
    logic       exp_err;
    logic [7:0] exp_rx;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {lp_dout, lp_clk_out, lp_clk_oe, done, err, busy, rx_data},
        {2'b11, 4'b0000, 8'h00});
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, lows, badlen, fall_cyc, oe_bad, last_edge, end_cyc, rel, k, ph, lat;
    logic prev_out, done_seen, err_seen;
    logic [7:0] dcap;
    lows = 0; badlen = 0; fall_cyc = 0; oe_bad = 0; last_edge = 0; end_cyc = -1;
    done_seen = 1'b0; err_seen = 1'b0; dcap = 8'h00;
    loop_en = v.loop; din_drv = 1'b1; lp_clk_in = 1'b1;
    @(negedge clk_8m);
    tx_data = v.tx; int_clk = v.master; start = 1'b1;
    @(posedge clk_8m); #1;
    start = 1'b0; tx_data = ~v.tx;
    cyc = 0; prev_out = 1'b1;
    chk({tag, "_busy_rise"}, busy, 1);
    while (cyc <= 12000) begin
      if (done || err) begin
        done_seen = done; err_seen = err; end_cyc = cyc;
        break;
      end
      if (lp_clk_oe !== v.master) oe_bad++;
      if (prev_out && !lp_clk_out) begin
        fall_cyc = cyc;
        if (v.master && lows < 8) din_drv = v.din[7-lows];
        lows++;
      end
      if (!prev_out && lp_clk_out) begin
        if (cyc - fall_cyc != CLK_HALF) badlen++;
        dcap = {dcap[6:0], lp_dout};
      end
      prev_out = lp_clk_out;
      if (!v.master) begin
        rel = cyc - 50;
        if (rel >= 0 && rel < v.nclk * PERIOD) begin
          ph = rel % PERIOD;
          k  = rel / PERIOD;
          if (ph == 0) begin
            lp_clk_in = 1'b0; din_drv = v.din[7-k]; last_edge = cyc;
          end else if (ph == CLK_HALF) begin
            dcap = {dcap[6:0], lp_dout}; lp_clk_in = 1'b1; last_edge = cyc;
          end
        end
      end
      @(posedge clk_8m); #1;
      cyc++;
    end
    chk({tag, "_end_event"}, {done_seen, err_seen}, v.exp_err ? 2'b01 : 2'b10);
    lat = end_cyc - last_edge;
    if (v.master)
      chk({tag, "_done_cycle"}, end_cyc, 16 * CLK_HALF);
    else if (v.exp_err)
      chk({tag, "_timeout_lat_ok"}, (lat >= TIMEOUT + 1 && lat <= TIMEOUT + 5), 1);
    else
      chk({tag, "_slave_lat_ok"}, (lat >= 2 && lat <= 6), 1);
    chk({tag, "_rx_data"}, rx_data, v.exp_rx);
    if (!v.exp_err) chk({tag, "_dout_bits"}, dcap, v.exp_dout);
    chk({tag, "_low_pulses"}, lows, v.master ? 8 : 0);
    chk({tag, "_bad_low_len"}, badlen, 0);
    chk({tag, "_oe_bad"}, oe_bad, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_oe_end"}, lp_clk_oe, 0);
    @(posedge clk_8m); #1;
    chk({tag, "_pulse_one_cycle"}, {done, err}, 2'b00);
  endtask

  initial begin
    int ndone, nerr, done_at;
    n_total = 0; n_pass = 0;
    rst_n = 1'b0; lp_clk_in = 1'b1; din_drv = 1'b1; loop_en = 1'b0;
    tx_data = 8'h00; start = 1'b0; int_clk = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'h00, 8, 1'b0, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8, 1'b0, 8'h00, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 8'h81, 8'hCA, 8, 1'b0, 8'hCA, 8'h81};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 8'hA0, 3, 1'b1, 8'hCA, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h5A, 8'hFF, 8, 1'b0, 8'hFF, 8'h5A};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h35, 8, 1'b0, 8'h35, 8'h00};

    repeat (3) @(posedge clk_8m);
    #1 chk_reset_vals("reset_values");
    @(negedge clk_8m) rst_n = 1'b1;
    repeat (5) @(posedge clk_8m);
    #1 chk_reset_vals("idle_after_reset");

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      repeat (20) @(posedge clk_8m);
      #1;
    end

    // Repeated start during a master transfer must not disturb it.
    loop_en = 1'b0; din_drv = 1'b1; ndone = 0; nerr = 0; done_at = -1;
    @(negedge clk_8m);
    tx_data = 8'h96; int_clk = 1'b1; start = 1'b1;
    @(posedge clk_8m); #1;
    start = 1'b0;
    for (int c = 0; c <= 8200; c++) begin
      if (done) begin ndone++; if (done_at < 0) done_at = c; end
      if (err) nerr++;
      start = (c == 100 || c == 3000);
      tx_data = 8'h00; int_clk = 1'b0;
      @(posedge clk_8m); #1;
    end
    start = 1'b0;
    chk("rep_start_done_count", ndone, 1);
    chk("rep_start_done_cycle", done_at, 16 * CLK_HALF);
    chk("rep_start_no_err", nerr, 0);
    chk("rep_start_rx", rx_data, 8'hFF);

    // Reset asserted around bit 4 of a master transfer.
    @(negedge clk_8m);
    tx_data = 8'hC3; int_clk = 1'b1; start = 1'b1;
    @(posedge clk_8m); #1;
    start = 1'b0;
    ndone = 0; nerr = 0;
    for (int c = 0; c < 4 * PERIOD + 100; c++) begin
      if (done) ndone++;
      if (err) nerr++;
      @(posedge clk_8m); #1;
    end
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1 chk_reset_vals("midrst_values");
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_8m); #1;
      if (done) ndone++;
      if (err) nerr++;
    end
    @(negedge clk_8m) rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk_8m); #1;
      if (done) ndone++;
      if (err) nerr++;
    end
    chk("midrst_no_done_err", {ndone[3:0], nerr[3:0]}, 8'h00);
    chk_reset_vals("midrst_idle_after");
    run_vec(vecs[0], "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
